// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map,
// sequencer states and the 18-bit counter word type.
package pll_cfg_pkg;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C     = 6'd5;
    localparam logic [5:0] ADDR_K     = 6'd7;

    // N/M/C word: [17] odd, [16] bypass, [15:8] hi, [7:0] lo
    typedef logic [17:0] cnt_word_t;

    typedef enum logic [3:0] {
        IDLE,
        W_MODE,
        W_N,
        W_M,
        W_K,
        W_C,
        W_START,
        HOLDOFF,
        WAIT_LOCK,
        DONE
    } state_t;

    // C counter write: counter select sits above the 18-bit counter word
    function automatic logic [31:0] c_word_data(input logic [4:0] idx, input cnt_word_t w);
        return {9'b0, idx, w};
    endfunction

endpackage

// File: rtl/pll_cfg_seq_lock_wait.sv
// Lock detection for the sequencer: 2-FF synchroniser on pll_locked plus the
// saturating holdoff and relock-timeout counters.
module pll_lock_wait #(
    parameter int LOCK_HOLDOFF = 16,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_locked,
    input  logic hold_active,
    input  logic wait_active,
    output logic hold_done,
    output logic lock_ok,
    output logic lock_timeout
);

    localparam int HOLD_W    = (LOCK_HOLDOFF > 0) ? $clog2(LOCK_HOLDOFF + 1) : 1;
    localparam int TO_W      = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam int HOLD_LAST = (LOCK_HOLDOFF > 1) ? LOCK_HOLDOFF - 1 : 0;
    localparam int TO_LAST   = (LOCK_TIMEOUT > 1) ? LOCK_TIMEOUT - 1 : 0;

    logic [1:0]        sync_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TO_W-1:0]   wait_cnt;

    // Counters are cleared whenever their phase is inactive, so each phase
    // always starts from zero and then saturates at its parameter value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            hold_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            sync_q <= {sync_q[0], pll_locked};

            if (!hold_active) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_W'(LOCK_HOLDOFF)) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end

            if (!wait_active) begin
                wait_cnt <= '0;
            end else if (wait_cnt != TO_W'(LOCK_TIMEOUT)) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end
        end
    end

    // Each phase lasts exactly its parameter's number of cycles
    assign hold_done    = hold_active && (hold_cnt >= HOLD_W'(HOLD_LAST));
    assign lock_ok      = wait_active && sync_q[1];
    assign lock_timeout = wait_active && (wait_cnt >= TO_W'(TO_LAST));

endmodule

// File: rtl/pll_cfg_seq.sv
// Runtime PLL reconfiguration sequencer: latches a counter set, writes it over
// the Avalon-MM management port, starts reconfiguration and waits for relock.
module pll_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter int NUM_CCNT     = 2,
    parameter int LOCK_HOLDOFF = 16,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int SKIP_SAME    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic [17:0]              cfg_n,
    input  logic [17:0]              cfg_m,
    input  logic [31:0]              cfg_k,
    input  logic [18*NUM_CCNT-1:0]   cfg_c,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic                     pll_locked,
    output logic [5:0]               mgmt_address,
    output logic [31:0]              mgmt_writedata,
    output logic                     mgmt_write,
    input  logic                     mgmt_waitrequest,
    output logic [3:0]               dbg_state
);

    localparam int CW    = 18 * NUM_CCNT;
    localparam int SET_W = 18 + 18 + 32 + CW;

    state_t           state, state_next;
    cnt_word_t        lat_n, lat_m;
    logic [31:0]      lat_k;
    logic [CW-1:0]    lat_c;
    logic [4:0]       idx;
    logic             err_q;
    logic             last_ok;
    logic [SET_W-1:0] last_set;
    logic [SET_W-1:0] lat_set;
    logic [SET_W-1:0] cfg_set;
    cnt_word_t        cur_c;
    logic             c_last;
    logic             accept;
    logic             skip_hit;
    logic             wr_ack;
    logic             hold_done, lock_ok, lock_timeout;

    assign lat_set  = {lat_n, lat_m, lat_k, lat_c};
    assign cfg_set  = {cfg_n, cfg_m, cfg_k, cfg_c};
    assign accept   = (state == IDLE) && req;
    // The incoming set is what gets latched on this edge, so compare it directly
    assign skip_hit = (SKIP_SAME != 0) && last_ok && (cfg_set == last_set);
    assign c_last   = (idx == 5'(NUM_CCNT - 1));

    // Handshake: mgmt_write is valid, !mgmt_waitrequest is ready; a write
    // transfers on a clock edge where both hold, and address/data stay
    // stable from the first cycle of valid until that edge.
    assign wr_ack = mgmt_write && !mgmt_waitrequest;

    always_comb begin
        cur_c = '0;
        for (int i = 0; i < NUM_CCNT; i++) begin
            if (idx == 5'(i)) cur_c = lat_c[18*i +: 18];
        end
    end

    pll_lock_wait #(
        .LOCK_HOLDOFF (LOCK_HOLDOFF),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_wait (
        .clk          (clk),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .hold_active  (state == HOLDOFF),
        .wait_active  (state == WAIT_LOCK),
        .hold_done    (hold_done),
        .lock_ok      (lock_ok),
        .lock_timeout (lock_timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lat_n    <= '0;
            lat_m    <= '0;
            lat_k    <= '0;
            lat_c    <= '0;
            idx      <= '0;
            err_q    <= 1'b0;
            last_ok  <= 1'b0;
            last_set <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_n <= cfg_n;
                lat_m <= cfg_m;
                lat_k <= cfg_k;
                lat_c <= cfg_c;
                idx   <= '0;
                err_q <= 1'b0;
            end
            if (state == W_C && wr_ack && !c_last) idx <= idx + 5'd1;
            if (state == WAIT_LOCK && !lock_ok && lock_timeout) err_q <= 1'b1;
            if (state == DONE) begin
                if (err_q) begin
                    last_ok <= 1'b0;
                end else begin
                    last_ok  <= 1'b1;
                    last_set <= lat_set;
                end
            end
        end
    end

    always_comb begin
        state_next     = state;
        mgmt_write     = 1'b0;
        mgmt_address   = '0;
        mgmt_writedata = '0;
        unique case (state)
            IDLE: begin
                if (req) state_next = skip_hit ? DONE : W_MODE;
            end
            W_MODE: begin
                mgmt_write   = 1'b1;
                mgmt_address = ADDR_MODE;
                if (!mgmt_waitrequest) state_next = W_N;
            end
            W_N: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_N;
                mgmt_writedata = {14'b0, lat_n};
                if (!mgmt_waitrequest) state_next = W_M;
            end
            W_M: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_M;
                mgmt_writedata = {14'b0, lat_m};
                if (!mgmt_waitrequest) state_next = W_K;
            end
            W_K: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_K;
                mgmt_writedata = lat_k;
                if (!mgmt_waitrequest) state_next = W_C;
            end
            W_C: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_C;
                mgmt_writedata = c_word_data(idx, cur_c);
                if (!mgmt_waitrequest && c_last) state_next = W_START;
            end
            W_START: begin
                mgmt_write   = 1'b1;
                mgmt_address = ADDR_START;
                if (!mgmt_waitrequest) state_next = HOLDOFF;
            end
            HOLDOFF: begin
                if (hold_done) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_ok || lock_timeout) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Bench for pll_cfg_seq: randomized requests and stalls checked by a
// scoreboard fed from a register-map level model of the reconfiguration flow.
module tb_pll_cfg_seq;

  localparam int NC = 2;
  localparam int H  = 16;
  localparam int T  = 100;

  logic clk, reset, req, pll_locked, mgmt_waitrequest;
  logic [17:0] cfg_n, cfg_m;
  logic [31:0] cfg_k;
  logic [18*NC-1:0] cfg_c;
  logic busy, done, err, mgmt_write;
  logic [5:0] mgmt_address;
  logic [31:0] mgmt_writedata;
  logic [3:0] dbg_state;

  logic ns_req, ns_busy, ns_done, ns_err, ns_write;
  logic [5:0] ns_addr;
  logic [31:0] ns_data;
  logic [3:0] ns_dbg;
  logic ns_wait, ns_locked;

  pll_cfg_seq #(.NUM_CCNT(NC), .LOCK_HOLDOFF(H), .LOCK_TIMEOUT(T), .SKIP_SAME(1)) u_dut (
    .clk(clk), .reset(reset), .req(req), .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_k(cfg_k),
    .cfg_c(cfg_c), .busy(busy), .done(done), .err(err), .pll_locked(pll_locked),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata), .mgmt_write(mgmt_write),
    .mgmt_waitrequest(mgmt_waitrequest), .dbg_state(dbg_state)
  );

  pll_cfg_seq #(.NUM_CCNT(NC), .LOCK_HOLDOFF(H), .LOCK_TIMEOUT(T), .SKIP_SAME(0)) u_dut_ns (
    .clk(clk), .reset(reset), .req(ns_req), .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_k(cfg_k),
    .cfg_c(cfg_c), .busy(ns_busy), .done(ns_done), .err(ns_err), .pll_locked(ns_locked),
    .mgmt_address(ns_addr), .mgmt_writedata(ns_data), .mgmt_write(ns_write),
    .mgmt_waitrequest(ns_wait), .dbg_state(ns_dbg)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [37:0] exp_q[$];
  logic        exp_err_q[$];
  int errors = 0;
  int checks = 0;
  int lock_delay = -1;
  int lock_raise_cyc = -1;
  int exp_done_cyc = -1;
  int start_cyc = 0;
  int first_acc_cyc = 0;
  bit burst_chk = 0;
  bit stall_en = 0;
  bit force_k = 0;
  bit mon_en = 1;
  int stall_left = 0;
  bit held_v = 0;
  logic [37:0] held;
  logic [37:0] e;
  logic e_err;
  logic [18*NC+67:0] m_last;
  bit m_last_ok = 0;
  logic m_err = 0;
  int ns_writes = 0;
  int ns_dones = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- slave stall driver ----------------
  always @(posedge clk) begin
    #1;
    if (force_k && mgmt_write && mgmt_address == 6'd7) begin
      mgmt_waitrequest = 1'b1;
    end else if (stall_left > 0) begin
      mgmt_waitrequest = 1'b1;
      stall_left--;
    end else begin
      mgmt_waitrequest = 1'b0;
      stall_left = stall_en ? int'($urandom_range(0, 7)) : 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (mgmt_write) begin
        if (held_v) check("hold_stable", {mgmt_address, mgmt_writedata}, held);
        if (mgmt_waitrequest) begin
          held_v = 1;
          held = {mgmt_address, mgmt_writedata};
        end else begin
          held_v = 0;
          if (exp_q.size() == 0) begin
            fail("unexpected_write");
          end else begin
            e = exp_q.pop_front();
            check("write_addr_data", {mgmt_address, mgmt_writedata}, e);
          end
          if (mgmt_address == 6'd0) first_acc_cyc = cyc + 1;
          if (mgmt_address == 6'd2) begin
            start_cyc = cyc + 1;
            if (burst_chk) check("burst_cycles", 64'(start_cyc - first_acc_cyc), 64'(NC + 4));
            if (lock_delay >= 0) begin
              lock_raise_cyc = start_cyc + H + lock_delay;
              exp_done_cyc = lock_raise_cyc + 3;
            end else begin
              exp_done_cyc = start_cyc + H + T;
            end
          end
        end
      end else if (held_v) begin
        fail("write_dropped_while_stalled");
        held_v = 0;
      end
      if (cyc == lock_raise_cyc) pll_locked = 1'b1;
      if (done) begin
        if (exp_err_q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          e_err = exp_err_q.pop_front();
          check("done_err", err, e_err);
          check("done_cycle", 64'(cyc), 64'(exp_done_cyc));
          check("busy_with_done", busy, 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ns_write) ns_writes++;
      if (ns_done) ns_dones++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic randomize_cfg();
    cfg_n = 18'($urandom());
    cfg_m = 18'($urandom());
    cfg_k = $urandom();
    cfg_c = (18*NC)'({$urandom(), $urandom()});
  endtask

  // Issue one request; ldelay < 0 keeps pll_locked low (timeout expected)
  task automatic do_req(input bit same, input int ldelay);
    logic [18*NC+67:0] set;
    bit skip;
    bit e_to;
    @(negedge clk);
    check("err_held", err, m_err);
    if (!same) randomize_cfg();
    set = {cfg_n, cfg_m, cfg_k, cfg_c};
    skip = m_last_ok && (set == m_last);
    pll_locked = 1'b0;
    lock_raise_cyc = -1;
    lock_delay = ldelay;
    if (skip) begin
      exp_err_q.push_back(1'b0);
      m_err = 1'b0;
    end else begin
      exp_q.push_back({6'd0, 32'd0});
      exp_q.push_back({6'd3, 14'd0, cfg_n});
      exp_q.push_back({6'd4, 14'd0, cfg_m});
      exp_q.push_back({6'd7, cfg_k});
      for (int i = 0; i < NC; i++) exp_q.push_back({6'd5, 9'd0, 5'(i), cfg_c[18*i +: 18]});
      exp_q.push_back({6'd2, 32'd0});
      e_to = (ldelay < 0);
      exp_err_q.push_back(e_to);
      m_err = e_to;
      m_last_ok = !e_to;
      if (!e_to) m_last = set;
    end
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    exp_done_cyc = skip ? cyc : -1;
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    check(skip ? "skip_no_write" : "first_write", mgmt_write, skip ? 1'b0 : 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_err_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail("wait_idle_timeout");
    check("writes_left", 64'(exp_q.size()), 0);
  endtask

  task automatic ns_run();
    int n = 0;
    @(negedge clk);
    ns_req = 1'b1;
    @(negedge clk);
    ns_req = 1'b0;
    while (ns_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("ns_timeout");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; req = 1'b0; ns_req = 1'b0; pll_locked = 1'b0; mgmt_waitrequest = 1'b0;
    ns_wait = 1'b0; ns_locked = 1'b1;
    cfg_n = '0; cfg_m = '0; cfg_k = '0; cfg_c = '0; m_last = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_write", mgmt_write, 0);
    check("rst_addr", mgmt_address, 0);
    check("rst_data", mgmt_writedata, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;

    // directed: no stalls, lock 5 cycles after holdoff
    burst_chk = 1;
    do_req(0, 5);
    wait_idle();
    // identical request: skipped
    do_req(1, 0);
    wait_idle();
    burst_chk = 0;

    // random stalls, repeats and occasional timeouts
    stall_en = 1;
    for (int it = 0; it < 10; it++) begin
      do_req($urandom_range(0, 3) == 0, ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 8)));
      wait_idle();
    end
    stall_en = 0;

    // timeout, then identical request must rewrite everything
    do_req(0, -1);
    wait_idle();
    do_req(1, 3);
    wait_idle();

    // req pulses while busy are ignored
    do_req(0, 6);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req = 1'($urandom_range(0, 1));
      randomize_cfg();
    end
    req = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    // reset during a stalled K write
    force_k = 1;
    do_req(0, 5);
    begin
      bit found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
        @(posedge clk);
        #2;
        if (mgmt_write && mgmt_address == 6'd7) found = 1;
      end
      if (!found) fail("reach_w_k");
    end
    mon_en = 0;
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("midrst_write", mgmt_write, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    reset = 1'b0;
    force_k = 0;
    exp_q.delete();
    exp_err_q.delete();
    held_v = 0;
    lock_raise_cyc = -1;
    pll_locked = 1'b0;
    m_last_ok = 0;
    m_err = 1'b0;
    mon_en = 1;
    do_req(1, 4);
    wait_idle();

    // SKIP_SAME=0 instance rewrites an identical set
    ns_writes = 0;
    ns_dones = 0;
    randomize_cfg();
    ns_run();
    ns_run();
    check("ns_writes", 64'(ns_writes), 64'(2 * (5 + NC)));
    check("ns_dones", 64'(ns_dones), 2);
    check("ns_err", ns_err, 0);

    check("exp_q_empty", 64'(exp_q.size()), 0);
    check("exp_err_q_empty", 64'(exp_err_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    fail("global_watchdog");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
